// File: rtl/hack_ram_dp.sv
// hack_ram_dp: dual-port HACK data RAM with post-reset clear sweep.
// Define HACK_RAM_BYPASS_EN for write-first collisions; otherwise reads return old data.
module hack_ram_dp #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 13,
  parameter int DEPTH = 8192,
  parameter logic [WIDTH-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic [WIDTH-1:0]  out_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  out_b,
  output logic              ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t st;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic a_ok, b_ok, wr, we, hit_a, hit_b;
  logic [AW-1:0] wa;
  logic [WIDTH-1:0] wd, rd_a, rd_b;
  always_comb begin
    a_ok = {1'b0, addr_a} < LIM;
    b_ok = {1'b0, addr_b} < LIM;
    wr = st == RUN && !clear && load_a && a_ok;
    // rst_n gates the sweep write so a held reset leaves the array untouched
    we = rst_n && (st == CLEAR || wr);
    wa = st == CLEAR ? cnt[AW-1:0] : addr_a[AW-1:0];
    wd = st == CLEAR ? FILL : data_a;
`ifdef HACK_RAM_BYPASS_EN
    hit_a = wr;
    hit_b = wr && addr_b == addr_a;
`else
    hit_a = 1'b0;
    hit_b = 1'b0;
`endif
    rd_a = !a_ok ? '0 : hit_a ? data_a : mem[addr_a[AW-1:0]];
    rd_b = !b_ok ? '0 : hit_b ? data_a : mem[addr_b[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= CLEAR;
      cnt <= '0;
      ready <= 1'b0;
      out_a <= '0;
      out_b <= '0;
    end else if (st == CLEAR) begin
      out_a <= '0;
      out_b <= '0;
      if (cnt == LAST) begin
        st <= RUN;
        ready <= 1'b1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end else if (clear) begin
      st <= CLEAR;
      ready <= 1'b0;
      out_a <= '0;
      out_b <= '0;
    end else begin
      out_a <= rd_a;
      out_b <= rd_b;
    end
  end
endmodule

// File: tb/tb_hack_ram_dp.sv
// tb_hack_ram_dp: directed checks of sweep latency, port reads, collisions, clear and reset abort.
module tb_hack_ram_dp;
  localparam logic [15:0] F = 16'hA5A5;
  logic clk = 0, rst_n = 0, clear = 0, load_a = 0;
  logic [4:0] addr_a = 0, addr_b = 0;
  logic [15:0] data_a = 0, out_a, out_b;
  logic ready;
  int total = 0, bad = 0, n;

  hack_ram_dp #(.WIDTH(16), .ADDR_W(5), .DEPTH(16), .FILL(F)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_a(load_a), .addr_a(addr_a),
    .data_a(data_a), .out_a(out_a), .addr_b(addr_b), .out_b(out_b), .ready(ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick;
      cnt++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    load_a = 1; addr_a = a; data_a = d;
    tick;
    load_a = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    addr_a = a; addr_b = b;
    tick;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_ready", ready, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    rst_n = 1;
    tick;
    chk("sweep_ready_low", ready, 0);
    chk("sweep_out_a", out_a, 0);
    wait_ready(n);
    chk("sweep_latency", n + 1, 16);
    for (int i = 0; i < 16; i++) begin
      rd(5'(i), 5'(15 - i));
      chk("fill_a", out_a, F);
      chk("fill_b", out_b, F);
    end
    wr(3, 16'h1234);
    rd(3, 3);
    chk("wr3_a", out_a, 16'h1234);
    chk("wr3_b", out_b, 16'h1234);
    addr_b = 5;
    wr(5, 16'hBEEF);
`ifdef HACK_RAM_BYPASS_EN
    chk("coll_b", out_b, 16'hBEEF);
    chk("coll_a", out_a, 16'hBEEF);
`else
    chk("coll_b", out_b, F);
    chk("coll_a", out_a, F);
`endif
    rd(5, 5);
    chk("coll_next_b", out_b, 16'hBEEF);
    wr(20, 16'h7777);
    rd(20, 4);
    chk("oor_a", out_a, 0);
    chk("oor_b", out_b, F);
    clear = 1; load_a = 1; addr_a = 2; data_a = 16'h0042;
    tick;
    clear = 0; load_a = 0;
    chk("clr_ready", ready, 0);
    chk("clr_out_a", out_a, 0);
    wait_ready(n);
    chk("clr_latency", n, 16);
    rd(2, 3);
    chk("clr_mem2", out_a, F);
    chk("clr_mem3", out_b, F);
    wr(9, 16'h5555);
    clear = 1;
    tick;
    clear = 0;
    repeat (6) tick;
    chk("mid_ready", ready, 0);
    rst_n = 0;
    #1;
    chk("abort_ready", ready, 0);
    chk("abort_out_b", out_b, 0);
    tick;
    tick;
    rst_n = 1;
    wait_ready(n);
    chk("abort_latency", n, 16);
    for (int i = 0; i < 16; i++) begin
      rd(5'(i), 5'(i));
      chk("refill_a", out_a, F);
      chk("refill_b", out_b, F);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hack_ram_dp.md
# hack_ram_dp

Parametrised dual-port data memory for the HACK system, the successor to the fixed 16-bit × 8K RAM block. Port A is the CPU read/write port and port B is a read-only port for the screen/peripheral scanner. After reset, a hardware clear sequencer sweeps the whole array to a fill value and holds `ready` low until the sweep completes. The block sits between the CPU data bus and the memory-mapped display logic.

## Interface
- `WIDTH`, 16: data word width in bits.
- `ADDR_W`, 13: address width of both ports.
- `DEPTH`, 8192: number of implemented words. Must satisfy DEPTH ≤ 2**ADDR_W and DEPTH ≥ 2.
- `FILL`, 0: WIDTH-bit value written to every word by the clear sweep.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: request a new clear sweep; sampled only while `ready`=1.
- `load_a`  in  1: port A write enable.
- `addr_a`  in  ADDR_W: port A address.
- `data_a`  in  WIDTH: port A write data.
- `out_a`  out  WIDTH: port A registered read data.
- `addr_b`  in  ADDR_W: port B read address.
- `out_b`  out  WIDTH: port B registered read data.
- `ready`  out  1: array initialised and ports active.

## Operation
- The FSM has two states: CLEAR and RUN. A clear counter `cnt` (ADDR_W bits) drives the sweep.
- On reset (`rst_n`=0), the block immediately enters CLEAR with `cnt`=0, `ready`=0, `out_a`=0 and `out_b`=0. Array contents are not touched by reset itself.
- CLEAR state, on each edge:
  - write FILL to mem[cnt], then increment `cnt`.
  - On the edge where `cnt`==DEPTH-1: go to RUN, set `ready`=1, set `cnt`=0.
  - `load_a` and `clear` are ignored.
  - `out_a` and `out_b` are held at 0.
- RUN state, on each edge:
  - If `clear`=1: go to CLEAR and set `ready`=0. Any `load_a` on the same edge is dropped (clear wins). Outputs load 0.
  - Otherwise, if `load_a`=1 and `addr_a`<DEPTH: mem[addr_a] ← `data_a`.
  - `out_a` ← mem[addr_a] and `out_b` ← mem[addr_b]. Any address ≥ DEPTH reads 0, and writes to such addresses are discarded.
- Same-address write collision (A write, B read of the same address): the result follows the Configuration section.
- Both ports are free-running in RUN. There is no handshake beyond `ready`.

## Timing
- Read latency is 1 cycle on both ports: an address presented before edge N appears on `out_*` after edge N.
- A write is visible to a read issued on the next edge.
- A clear sweep takes exactly DEPTH edges. `ready` rises on the DEPTH-th edge after `rst_n` release, or after the edge that sampled `clear`=1.
- Reset asserted mid-sweep aborts the sweep asynchronously. On release, the sweep restarts from address 0 and takes the full DEPTH edges again.
- `ready` falls on the same edge that samples `clear`=1 in RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `HACK_RAM_BYPASS_EN`, when defined: a read on either port of the address being written by port A on the same edge returns `data_a` (write-first).
- When undefined: read-before-write. Both ports return the old contents on a collision edge, and the new value appears one cycle later. This is the legacy behaviour.
- The macro has no effect during CLEAR; outputs are 0 there regardless.

## Test plan
- DEPTH=16, FILL=16'hA5A5. Release `rst_n`, then read addresses 0..15 on both ports after `ready` → `ready` rises after exactly 16 edges, and every read returns 16'hA5A5.
- In RUN, write 16'h1234 to address 3. On the next edge read address 3 on A and B → both outputs give 16'h1234 one cycle later.
- Same edge: `load_a`=1, `addr_a`=5, `data_a`=16'hBEEF, `addr_b`=5, with old mem[5]=16'hA5A5 → `out_b`=16'hBEEF with `HACK_RAM_BYPASS_EN` defined, 16'hA5A5 without it. On the following edge, `out_b`=16'hBEEF in both builds.
- Assert `rst_n`=0 at sweep edge 7, release, then count edges → `ready`=0 immediately on assertion, rises again 16 edges after release, and all words read FILL.
- In RUN, assert `clear`=1 together with `load_a`=1, `addr_a`=2, `data_a`=16'h0042 → `ready`=0 next cycle, and after 16 edges mem[2] reads FILL, not 16'h0042.
- With ADDR_W=5 and DEPTH=16, write 16'h7777 to address 20, then read address 20 and address 4 → address 20 reads 0 and address 4 is unchanged.
